alu_div_serial: RTL and testbench

- Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU in the execute stage, next to the single-cycle alu.
- Consumes the same operand_a/operand_b/operator bundle that the alu receives.
- Produces one word result through a valid/ready handshake toward the EX/WB mux.
- Divides one quotient bit per clock. Handles division-by-zero and signed overflow with a one-cycle fast path.

---
 rtl/alu_div_serial_pkg.sv | 28 ++
 rtl/alu_div_serial_if.sv | 28 ++
 rtl/alu_div_serial_step.sv | 26 ++
 rtl/alu_div_serial.sv | 122 ++++++++++++
 tb/tb_alu_div_serial.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_div_serial_pkg.sv
// Shared RV32M divider definitions: word width, ALU operator encodings and
// the divider FSM state type.
package riscv_defines;

  localparam int WORD_WIDTH   = 32;
  localparam int ALU_OP_WIDTH = 7;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    FINISH
  } div_state_t;

  // Any code other than the four division operators is handled as DIVU.
  function automatic logic is_signed_op(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [ALU_OP_WIDTH-1:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_div_serial_if.sv
// Request/result bundle between the execute stage and the serial divider.
interface alu_div_serial_if
  import riscv_defines::*;
#(
  parameter int WIDTH = WORD_WIDTH
) ();

  logic                    valid_i;
  logic                    ready_o;
  logic [ALU_OP_WIDTH-1:0] operator_i;
  logic [WIDTH-1:0]        operand_a_i;
  logic [WIDTH-1:0]        operand_b_i;
  logic                    kill_i;
  logic                    valid_o;
  logic                    ready_i;
  logic [WIDTH-1:0]        result_o;

  modport master (
    output valid_i, operator_i, operand_a_i, operand_b_i, kill_i, ready_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  valid_i, operator_i, operand_a_i, operand_b_i, kill_i, ready_i,
    output ready_o, valid_o, result_o
  );

endinterface

// File: rtl/alu_div_serial_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and trial-subtract the divisor.
module alu_div_step
  import riscv_defines::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The remainder always stays below the divisor, so the kept value fits WIDTH bits.
  always_comb begin
    shifted  = {rem, dvd_msb};
    diff     = shifted - {1'b0, divisor};
    q_bit    = (shifted >= {1'b0, divisor});
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/alu_div_serial.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per
// clock, with a single-cycle path for division by zero and signed overflow.
module alu_div_serial
  import riscv_defines::*;
#(
  parameter int WIDTH     = WORD_WIDTH,
  parameter int CNT_WIDTH = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_div_serial_if.slave  bus
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0]     rem_q, dvd_q, dvs_q;
  logic                 neg_q, is_rem_q;

  logic                 accept, op_signed, op_rem, b_zero, overflow, fast;
  logic                 res_sign;
  logic [WIDTH-1:0]     a_abs, b_abs, fast_res, step_rem, mag;
  logic                 step_q;

  assign accept    = (state_q == IDLE) && bus.valid_i && !bus.kill_i;
  assign op_signed = is_signed_op(bus.operator_i);
  assign op_rem    = is_rem_op(bus.operator_i);
  assign b_zero    = (bus.operand_b_i == '0);
  assign overflow  = op_signed && (bus.operand_a_i == MIN_NEG) && (bus.operand_b_i == '1);
  assign fast      = b_zero || overflow;

  assign a_abs = (op_signed && bus.operand_a_i[WIDTH-1]) ? -bus.operand_a_i : bus.operand_a_i;
  assign b_abs = (op_signed && bus.operand_b_i[WIDTH-1]) ? -bus.operand_b_i : bus.operand_b_i;

  // Remainder takes the dividend's sign; quotient the XOR of both signs.
  assign res_sign = op_rem ? bus.operand_a_i[WIDTH-1]
                           : (bus.operand_a_i[WIDTH-1] ^ bus.operand_b_i[WIDTH-1]);

  assign fast_res = b_zero ? (op_rem ? bus.operand_a_i : '1)
                           : (op_rem ? '0 : MIN_NEG);

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = fast ? FINISH : DIVIDE;
      end
      DIVIDE: begin
        if (bus.kill_i)          state_d = IDLE;
        else if (cnt_q == '0)    state_d = FINISH;
      end
      FINISH: begin
        if (bus.kill_i || bus.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Fast-path results are parked in both rem and dividend registers with no
  // sign correction, so the common output mux serves either operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            is_rem_q <= op_rem;
            cnt_q    <= CNT_WIDTH'(WIDTH-1);
            if (fast) begin
              rem_q <= fast_res;
              dvd_q <= fast_res;
              dvs_q <= '0;
              neg_q <= 1'b0;
            end else begin
              rem_q <= '0;
              dvd_q <= a_abs;
              dvs_q <= b_abs;
              neg_q <= op_signed && res_sign;
            end
          end
        end
        DIVIDE: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[WIDTH-2:0], step_q};
          cnt_q <= cnt_q - CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mag          = is_rem_q ? rem_q : dvd_q;
    bus.ready_o  = (state_q == IDLE);
    bus.valid_o  = (state_q == FINISH);
    bus.result_o = (state_q == FINISH) ? (neg_q ? -mag : mag) : '0;
  end

endmodule

// File: tb/tb_alu_div_serial.sv
// Self-checking bench for alu_div_serial: directed corner cases, handshake,
// kill/reset behaviour and randomized operands against an arithmetic model.
module tb_alu_div_serial
  import riscv_defines::*;
();

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_div_serial_if #(.WIDTH(32)) bus ();

  alu_div_serial #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only the four division codes may ever be presented to the divider.
  always @(posedge clk) begin
    if (rst_n && bus.valid_i && bus.ready_o && !bus.kill_i)
      assert (bus.operator_i == ALU_DIV || bus.operator_i == ALU_DIVU ||
              bus.operator_i == ALU_REM || bus.operator_i == ALU_REMU)
        else $error("[TB] unsupported operator %h", bus.operator_i);
  end

  function automatic logic [31:0] ref_div(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    int  sa, sb;
    logic rem_op, sgn_op;
    rem_op = (op == ALU_REM) || (op == ALU_REMU);
    sgn_op = (op == ALU_REM) || (op == ALU_DIV);
    sa = a;
    sb = b;
    if (b == 32'd0) return rem_op ? a : 32'hFFFF_FFFF;
    if (sgn_op) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem_op ? 32'd0 : 32'h8000_0000;
      return rem_op ? 32'(sa % sb) : 32'(sa / sb);
    end
    return rem_op ? (a % b) : (a / b);
  endfunction

  // Edges from the accepting edge (counted as 1) until valid_o is seen.
  function automatic int ref_latency(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn_op;
    sgn_op = (op == ALU_REM) || (op == ALU_DIV);
    if (b == 32'd0 || (sgn_op && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int edges);
    bus.valid_i     = 1'b1;
    bus.operator_i  = op;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    tick();
    bus.valid_i = 1'b0;
    edges = 1;
    while (bus.valid_o !== 1'b1 && edges < 100) begin
      tick();
      edges++;
    end
    res = bus.result_o;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.result_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_held ready=%b valid=%b result=%h want 1 0 0", bus.ready_o, bus.valid_o, bus.result_o);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.result_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_release ready=%b valid=%b result=%h want 1 0 0", bus.ready_o, bus.valid_o, bus.result_o);
    end
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t        vecs [9];
    logic [31:0] res;
    int          edges;
    vecs = '{
      '{ALU_DIVU, 32'd100,        32'd7,          32'd14,         33},
      '{ALU_REMU, 32'd100,        32'd7,          32'd2,          33},
      '{ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33},
      '{ALU_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33},
      '{ALU_REMU, 32'hFFFF_FFF9,  32'd2,          32'd1,          33},
      '{ALU_DIVU, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1},
      '{ALU_REM,  32'h0000_1234,  32'd0,          32'h0000_1234,  1},
      '{ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1},
      '{ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1}
    };
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, edges);
      checks++;
      if (res !== vecs[i].exp) begin
        errors++;
        $display("FAIL directed_result[%0d] got %h want %h", i, res, vecs[i].exp);
      end
      checks++;
      if (edges !== vecs[i].lat) begin
        errors++;
        $display("FAIL directed_latency[%0d] got %0d want %0d", i, edges, vecs[i].lat);
      end
      tick();
      checks++;
      if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.result_o !== 32'd0) begin
        errors++;
        $display("FAIL directed_handshake[%0d] valid=%b ready=%b result=%h want 0 1 0",
                 i, bus.valid_o, bus.ready_o, bus.result_o);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int          edges;
    bus.ready_i = 1'b0;
    apply_stimulus(ALU_DIVU, 32'd50000, 32'd7, res, edges);
    checks++;
    if (res !== 32'd7142) begin
      errors++;
      $display("FAIL bp_result got %h want %h", res, 32'd7142);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.result_o !== 32'd7142) begin
        errors++;
        $display("FAIL bp_hold[%0d] valid=%b ready=%b result=%h want 1 0 %h",
                 k, bus.valid_o, bus.ready_o, bus.result_o, 32'd7142);
      end
    end
    bus.ready_i = 1'b1;
    tick();
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_release ready=%b valid=%b want 1 0", bus.ready_o, bus.valid_o);
    end
    apply_stimulus(ALU_DIVU, 32'd1000, 32'd10, res, edges);
    checks++;
    if (res !== 32'd100) begin
      errors++;
      $display("FAIL bp_second got %h want %h", res, 32'd100);
    end
    tick();
  endtask

  task automatic test_kill();
    logic seen;
    bus.valid_i     = 1'b1;
    bus.operator_i  = ALU_DIVU;
    bus.operand_a_i = 32'd987654;
    bus.operand_b_i = 32'd13;
    tick();
    bus.valid_i = 1'b0;
    repeat (9) tick();
    bus.kill_i = 1'b1;
    tick();
    bus.kill_i = 1'b0;
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_divide ready=%b valid=%b want 1 0", bus.ready_o, bus.valid_o);
    end
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen = seen | bus.valid_o;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL kill_no_valid saw valid=%b want 0", seen);
    end
    bus.valid_i     = 1'b1;
    bus.kill_i      = 1'b1;
    bus.operand_b_i = 32'd0;
    tick();
    bus.valid_i = 1'b0;
    bus.kill_i  = 1'b0;
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL kill_idle_block ready=%b valid=%b want 1 0", bus.ready_o, bus.valid_o);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int          edges;
    bus.valid_i     = 1'b1;
    bus.operator_i  = ALU_DIVU;
    bus.operand_a_i = 32'd123456;
    bus.operand_b_i = 32'd3;
    tick();
    bus.valid_i = 1'b0;
    repeat (5) tick();
    checks++;
    if (bus.ready_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_busy ready=%b want 0", bus.ready_o);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.result_o !== 32'd0) begin
      errors++;
      $display("FAIL arst_divide ready=%b valid=%b result=%h want 1 0 0", bus.ready_o, bus.valid_o, bus.result_o);
    end
    #1 rst_n = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    apply_stimulus(ALU_DIVU, 32'h1234, 32'd0, res, edges);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.result_o !== 32'd0) begin
      errors++;
      $display("FAIL arst_finish ready=%b valid=%b result=%h want 1 0 0", bus.ready_o, bus.valid_o, bus.result_o);
    end
    #1 rst_n = 1'b1;
    bus.ready_i = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [6:0]  ops [4];
    logic [6:0]  op;
    logic [31:0] a, b, res, exp;
    int          edges, lat, sel;
    ops = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    for (int i = 0; i < 1000; i++) begin
      op  = ops[$urandom_range(0, 3)];
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0)      b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel <= 4) b = $urandom_range(1, 255);
      else if (sel == 5) begin a = $urandom_range(0, 1000); b = $urandom_range(1, 2000); end
      else if (sel == 6) b = -($urandom_range(1, 100));
      exp = ref_div(op, a, b);
      lat = ref_latency(op, a, b);
      apply_stimulus(op, a, b, res, edges);
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL rand_result[%0d] op=%h a=%h b=%h got %h want %h", i, op, a, b, res, exp);
      end
      checks++;
      if (edges !== lat) begin
        errors++;
        $display("FAIL rand_latency[%0d] got %0d want %0d", i, edges, lat);
      end
      tick();
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.valid_i     = 1'b0;
    bus.operator_i  = ALU_DIVU;
    bus.operand_a_i = 32'd0;
    bus.operand_b_i = 32'd0;
    bus.kill_i      = 1'b0;
    bus.ready_i     = 1'b1;
    repeat (2) tick();
    test_reset();
    test_directed();
    test_backpressure();
    test_kill();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
